// File: rtl/issue_queue_param.sv
// issue_queue_param: collapsing instruction issue queue with operand wakeup.
// Slot 0 holds the oldest entry; valid entries are always contiguous from slot 0,
// so the occupancy count alone defines which slots are valid.
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   stall, flush                     downstream hold / discard everything
//   d_valid, d_ready, d_*            decode-side enqueue handshake and payload
//   d_rdy0, d_rdy1                   source operands already available at enqueue
//   wb_valid, wb_tag                 writeback wakeup broadcast (tag 0 wakes nothing)
//   e_valid, e_*                     registered issue slot
//   iq_count                         occupied entries
// OOO=0 issues from slot 0 only; OOO=1 issues the lowest-index ready slot.
module issue_queue_param #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int OOO    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         d_valid,
    output logic                         d_ready,
    input  logic                         d_regwrite,
    input  logic                         d_memtoreg,
    input  logic                         d_branch,
    input  logic                         d_memwrite,
    input  logic                         d_memread,
    input  logic                         d_regdst,
    input  logic                         d_alusrc,
    input  logic [1:0]                   d_aluop,
    input  logic [DATA_W-1:0]            d_pc,
    input  logic [DATA_W-1:0]            d_rd1,
    input  logic [DATA_W-1:0]            d_rd2,
    input  logic [DATA_W-1:0]            d_sigext,
    input  logic [4:0]                   d_inst1,
    input  logic [4:0]                   d_inst2,
    input  logic [4:0]                   d_inst3,
    input  logic                         d_rdy0,
    input  logic                         d_rdy1,
    input  logic                         wb_valid,
    input  logic [4:0]                   wb_tag,
    output logic                         e_valid,
    output logic                         e_regwrite,
    output logic                         e_memtoreg,
    output logic                         e_branch,
    output logic                         e_memwrite,
    output logic                         e_memread,
    output logic                         e_regdst,
    output logic                         e_alusrc,
    output logic [1:0]                   e_aluop,
    output logic [DATA_W-1:0]            e_pc,
    output logic [DATA_W-1:0]            e_rd1,
    output logic [DATA_W-1:0]            e_rd2,
    output logic [DATA_W-1:0]            e_sigext,
    output logic [4:0]                   e_inst1,
    output logic [4:0]                   e_inst2,
    output logic [4:0]                   e_inst3,
    output logic [$clog2(DEPTH+1)-1:0]   iq_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              branch;
        logic              memwrite;
        logic              memread;
        logic              regdst;
        logic              alusrc;
        logic [1:0]        aluop;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] sigext;
        logic [4:0]        inst1;
        logic [4:0]        inst2;
        logic [4:0]        inst3;
    } payload_t;

    payload_t          pay_q [DEPTH];
    payload_t          pay_n [DEPTH];
    logic [DEPTH-1:0]  r0_q, r1_q, r0_n, r1_n;
    logic [CW-1:0]     count_q, count_n, wp;
    payload_t          d_pay, e_pay_q;
    logic              found, issue, enq;
    logic [IW-1:0]     idx;

    assign d_pay = {d_regwrite, d_memtoreg, d_branch, d_memwrite, d_memread, d_regdst,
                    d_alusrc, d_aluop, d_pc, d_rd1, d_rd2, d_sigext,
                    d_inst1, d_inst2, d_inst3};

    assign d_ready  = (count_q < CW'(DEPTH));
    assign iq_count = count_q;

    // Candidate selection looks only at registered ready bits, so a wakeup
    // becomes visible for issue one cycle after it is broadcast.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (OOO == 0) begin
            found = (count_q != '0) && r0_q[0] && r1_q[0];
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if ((i < int'(count_q)) && r0_q[i] && r1_q[i]) begin
                    found = 1'b1;
                    idx   = IW'(i);
                end
            end
        end
    end

    assign issue = found && !stall && !flush;
    assign enq   = d_valid && d_ready && !flush;
    assign wp    = count_q - CW'(issue);

    // Order matters: collapse over the issued slot, then write the new entry,
    // then apply wakeup so an entry enqueued alongside its wakeup is caught.
    always_comb begin
        pay_n = pay_q;
        r0_n  = r0_q;
        r1_n  = r1_q;
        if (issue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i >= int'(idx)) begin
                    // Top slot wraps to slot 0; it is beyond the new count, so its content is don't-care.
                    pay_n[i] = pay_q[(i + 1) % DEPTH];
                    r0_n[i]  = r0_q[(i + 1) % DEPTH];
                    r1_n[i]  = r1_q[(i + 1) % DEPTH];
                end
            end
        end
        if (enq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(wp)) begin
                    pay_n[i] = d_pay;
                    r0_n[i]  = d_rdy0;
                    r1_n[i]  = d_rdy1;
                end
            end
        end
        if (wb_valid && (wb_tag != 5'd0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pay_n[i].inst1 == wb_tag) r0_n[i] = 1'b1;
                if (pay_n[i].inst2 == wb_tag) r1_n[i] = 1'b1;
            end
        end
    end

    always_comb begin
        count_n = count_q;
        if (flush) count_n = '0;
        else       count_n = count_q + CW'(enq) - CW'(issue);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) pay_q[i] <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            count_q <= '0;
        end else begin
            pay_q   <= pay_n;
            r0_q    <= r0_n;
            r1_q    <= r1_n;
            count_q <= count_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid <= 1'b0;
            e_pay_q <= '0;
        end else if (flush) begin
            e_valid <= 1'b0;
        end else if (!stall) begin
            e_valid <= found;
            if (found) e_pay_q <= pay_q[idx];
        end
    end

    assign e_regwrite = e_pay_q.regwrite;
    assign e_memtoreg = e_pay_q.memtoreg;
    assign e_branch   = e_pay_q.branch;
    assign e_memwrite = e_pay_q.memwrite;
    assign e_memread  = e_pay_q.memread;
    assign e_regdst   = e_pay_q.regdst;
    assign e_alusrc   = e_pay_q.alusrc;
    assign e_aluop    = e_pay_q.aluop;
    assign e_pc       = e_pay_q.pc;
    assign e_rd1      = e_pay_q.rd1;
    assign e_rd2      = e_pay_q.rd2;
    assign e_sigext   = e_pay_q.sigext;
    assign e_inst1    = e_pay_q.inst1;
    assign e_inst2    = e_pay_q.inst2;
    assign e_inst3    = e_pay_q.inst3;

endmodule

// File: tb/tb_issue_queue_param.sv
module tb_issue_queue_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        d_valid = 1'b0;
    logic        d_regwrite = 1'b0, d_memtoreg = 1'b0, d_branch = 1'b0, d_memwrite = 1'b0;
    logic        d_memread = 1'b0, d_regdst = 1'b0, d_alusrc = 1'b0;
    logic [1:0]  d_aluop = '0;
    logic [31:0] d_pc = '0, d_rd1 = '0, d_rd2 = '0, d_sigext = '0;
    logic [4:0]  d_inst1 = '0, d_inst2 = '0, d_inst3 = '0;
    logic        d_rdy0 = 1'b0, d_rdy1 = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_tag = '0;

    logic        d_ready, e_valid, e_regwrite, e_memtoreg, e_branch, e_memwrite;
    logic        e_memread, e_regdst, e_alusrc;
    logic [1:0]  e_aluop;
    logic [31:0] e_pc, e_rd1, e_rd2, e_sigext;
    logic [4:0]  e_inst1, e_inst2, e_inst3;
    logic [2:0]  iq_count;

    logic        o_d_ready, o_e_valid, o_e_regwrite, o_e_memtoreg, o_e_branch, o_e_memwrite;
    logic        o_e_memread, o_e_regdst, o_e_alusrc;
    logic [1:0]  o_e_aluop;
    logic [31:0] o_e_pc, o_e_rd1, o_e_rd2, o_e_sigext;
    logic [4:0]  o_e_inst1, o_e_inst2, o_e_inst3;
    logic [2:0]  o_iq_count;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    issue_queue_param #(.DEPTH(4), .DATA_W(32), .OOO(0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_regwrite(d_regwrite), .d_memtoreg(d_memtoreg), .d_branch(d_branch),
        .d_memwrite(d_memwrite), .d_memread(d_memread), .d_regdst(d_regdst),
        .d_alusrc(d_alusrc), .d_aluop(d_aluop), .d_pc(d_pc), .d_rd1(d_rd1),
        .d_rd2(d_rd2), .d_sigext(d_sigext), .d_inst1(d_inst1), .d_inst2(d_inst2),
        .d_inst3(d_inst3), .d_rdy0(d_rdy0), .d_rdy1(d_rdy1),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .e_valid(e_valid), .e_regwrite(e_regwrite), .e_memtoreg(e_memtoreg),
        .e_branch(e_branch), .e_memwrite(e_memwrite), .e_memread(e_memread),
        .e_regdst(e_regdst), .e_alusrc(e_alusrc), .e_aluop(e_aluop), .e_pc(e_pc),
        .e_rd1(e_rd1), .e_rd2(e_rd2), .e_sigext(e_sigext), .e_inst1(e_inst1),
        .e_inst2(e_inst2), .e_inst3(e_inst3), .iq_count(iq_count)
    );

    issue_queue_param #(.DEPTH(4), .DATA_W(32), .OOO(1)) dut_ooo (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_ready(o_d_ready),
        .d_regwrite(d_regwrite), .d_memtoreg(d_memtoreg), .d_branch(d_branch),
        .d_memwrite(d_memwrite), .d_memread(d_memread), .d_regdst(d_regdst),
        .d_alusrc(d_alusrc), .d_aluop(d_aluop), .d_pc(d_pc), .d_rd1(d_rd1),
        .d_rd2(d_rd2), .d_sigext(d_sigext), .d_inst1(d_inst1), .d_inst2(d_inst2),
        .d_inst3(d_inst3), .d_rdy0(d_rdy0), .d_rdy1(d_rdy1),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .e_valid(o_e_valid), .e_regwrite(o_e_regwrite), .e_memtoreg(o_e_memtoreg),
        .e_branch(o_e_branch), .e_memwrite(o_e_memwrite), .e_memread(o_e_memread),
        .e_regdst(o_e_regdst), .e_alusrc(o_e_alusrc), .e_aluop(o_e_aluop), .e_pc(o_e_pc),
        .e_rd1(o_e_rd1), .e_rd2(o_e_rd2), .e_sigext(o_e_sigext), .e_inst1(o_e_inst1),
        .e_inst2(o_e_inst2), .e_inst3(o_e_inst3), .iq_count(o_iq_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic r0, input logic r1,
                       input logic [4:0] i1, input logic [4:0] i2);
        d_valid    = v;
        d_pc       = pc;
        d_rdy0     = r0;
        d_rdy1     = r1;
        d_inst1    = i1;
        d_inst2    = i2;
        d_inst3    = 5'd3;
        d_regwrite = 1'b1;
        d_aluop    = 2'b10;
        d_rd1      = ~pc;
        d_rd2      = pc ^ 32'h5555_0000;
        d_sigext   = pc + 32'd1;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    // Scoreboard: every new issue from the in-order instance pops the oldest expected pc.
    always @(posedge clk) begin
        logic st, fl;
        logic [63:0] exp;
        st = stall;
        fl = flush;
        #1;
        if (rst && !st && !fl && e_valid) begin
            exp = (sb.size() > 0) ? {32'h0, sb.pop_front()} : 64'hFFFF_FFFF_FFFF_FFFF;
            chk("sb_issue_pc", {32'h0, e_pc}, exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        cyc();
        cyc();
        chk("rst_e_valid", e_valid, 0);
        chk("rst_count", iq_count, 0);
        chk("rst_d_ready", d_ready, 1);
        chk("rst_e_pc", e_pc, 0);
        rst = 1'b1;

        // single ready instruction issues one edge after enqueue
        drv(1'b1, 32'h100, 1'b1, 1'b1, 5'd0, 5'd0); sb.push_back(32'h100);
        cyc(); idle();
        chk("lat_count_after_enq", iq_count, 1);
        chk("lat_e_valid_pre", e_valid, 0);
        cyc();
        chk("lat_e_valid", e_valid, 1);
        chk("lat_e_pc", e_pc, 32'h100);
        chk("lat_count", iq_count, 0);
        cyc();
        chk("empty_e_valid", e_valid, 0);
        chk("empty_e_pc_hold", e_pc, 32'h100);

        // fill to full with unready entries, drop the fifth, wake all at once
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h200 + i, 1'b0, 1'b1, 5'd5, 5'd0); sb.push_back(32'h200 + i);
            cyc();
        end
        chk("full_count", iq_count, 4);
        chk("full_d_ready", d_ready, 0);
        drv(1'b1, 32'h2FF, 1'b0, 1'b1, 5'd5, 5'd0);
        cyc();
        chk("full_drop_count", iq_count, 4);
        idle(); wb_valid = 1'b1; wb_tag = 5'd5;
        cyc(); wb_valid = 1'b0;
        chk("wake_no_same_cycle_issue", e_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_e_valid", e_valid, 1);
            chk("drain_count", iq_count, 3 - i);
        end

        // head blocked: in-order waits, out-of-order issues the younger entry
        flush = 1'b1; cyc(); flush = 1'b0; sb.delete();
        drv(1'b1, 32'h300, 1'b0, 1'b1, 5'd7, 5'd0); sb.push_back(32'h300);
        cyc();
        drv(1'b1, 32'h301, 1'b1, 1'b1, 5'd0, 5'd0); sb.push_back(32'h301);
        cyc(); idle();
        cyc();
        chk("io_blocked_e_valid", e_valid, 0);
        chk("io_blocked_count", iq_count, 2);
        chk("ooo_e_valid", o_e_valid, 1);
        chk("ooo_e_pc", o_e_pc, 32'h301);
        chk("ooo_count", o_iq_count, 1);
        wb_valid = 1'b1; wb_tag = 5'd7;
        cyc(); wb_valid = 1'b0;
        chk("ooo_idle_e_valid", o_e_valid, 0);
        chk("ooo_idle_e_pc_hold", o_e_pc, 32'h301);
        chk("io_wake_e_valid", e_valid, 0);
        cyc();
        chk("io_head_e_pc", e_pc, 32'h300);
        chk("ooo_head_e_pc", o_e_pc, 32'h300);
        chk("ooo_head_count", o_iq_count, 0);
        chk("io_head_count", iq_count, 1);
        cyc();
        chk("io_second_e_pc", e_pc, 32'h301);
        chk("io_second_count", iq_count, 0);

        // stall holds the issue slot while enqueue continues
        stall = 1'b1;
        drv(1'b1, 32'h400, 1'b1, 1'b1, 5'd0, 5'd0); sb.push_back(32'h400);
        for (int i = 0; i < 3; i++) begin
            cyc(); idle();
            chk("stall_e_pc", e_pc, 32'h301);
            chk("stall_e_valid", e_valid, 1);
            chk("stall_count", iq_count, 1);
        end
        stall = 1'b0;
        cyc();
        chk("unstall_e_pc", e_pc, 32'h400);
        chk("unstall_count", iq_count, 0);

        // wakeup concurrent with enqueue
        drv(1'b1, 32'h500, 1'b1, 1'b0, 5'd0, 5'd9); sb.push_back(32'h500);
        wb_valid = 1'b1; wb_tag = 5'd9;
        cyc(); idle(); wb_valid = 1'b0;
        chk("enqwake_e_valid_pre", e_valid, 0);
        chk("enqwake_count", iq_count, 1);
        cyc();
        chk("enqwake_e_valid", e_valid, 1);
        chk("enqwake_e_pc", e_pc, 32'h500);

        // tag 0 never wakes anything
        drv(1'b1, 32'h600, 1'b0, 1'b1, 5'd0, 5'd0);
        wb_valid = 1'b1; wb_tag = 5'd0;
        cyc(); idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("tag0_e_valid", e_valid, 0);
            chk("tag0_count", iq_count, 1);
        end
        wb_valid = 1'b0;

        // flush beats a concurrent enqueue
        drv(1'b1, 32'h700, 1'b1, 1'b1, 5'd0, 5'd0); cyc();
        drv(1'b1, 32'h701, 1'b1, 1'b1, 5'd0, 5'd0); cyc();
        chk("preflush_count", iq_count, 3);
        drv(1'b1, 32'h7FF, 1'b1, 1'b1, 5'd0, 5'd0); flush = 1'b1;
        cyc(); flush = 1'b0; idle();
        chk("flush_count", iq_count, 0);
        chk("flush_e_valid", e_valid, 0);
        chk("flush_d_ready", d_ready, 1);
        cyc();
        chk("postflush_e_valid", e_valid, 0);
        chk("postflush_count", iq_count, 0);

        // asynchronous reset between edges
        drv(1'b1, 32'h800, 1'b1, 1'b1, 5'd0, 5'd0); sb.push_back(32'h800);
        cyc();
        drv(1'b1, 32'h801, 1'b0, 1'b1, 5'd3, 5'd0);
        cyc(); idle();
        chk("prerst_e_valid", e_valid, 1);
        chk("prerst_e_regwrite", e_regwrite, 1);
        chk("prerst_count", iq_count, 1);
        #2 rst = 1'b0; sb.delete();
        #1;
        chk("arst_e_valid", e_valid, 0);
        chk("arst_e_pc", e_pc, 0);
        chk("arst_e_regwrite", e_regwrite, 0);
        chk("arst_e_aluop", e_aluop, 0);
        chk("arst_e_rd1", e_rd1, 0);
        chk("arst_e_inst3", e_inst3, 0);
        chk("arst_count", iq_count, 0);
        chk("arst_d_ready", d_ready, 1);
        #1 rst = 1'b1;
        cyc();
        chk("postrst_e_valid", e_valid, 0);
        chk("postrst_count", iq_count, 0);
        cyc();
        chk("postrst_e_valid2", e_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
